mem_arbiter: RTL and testbench

- Shares the single-port, 256-word, 16-bit instruction/data memory between two requesters: the instruction-fetch port (read-only) and the load/store port (read/write).
- Grants one access per cycle using 2-way round-robin arbitration.
- Drives the memory's write_enable/read_enable/address/data_in, and routes the memory's 1-cycle-latency registered read data back to the requester that issued the read.
- Sits between the CPU core front end and the memory module; it is the only master of the memory.

---
 rtl/microcpu_mem_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 37 +++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/microcpu_mem_pkg.sv
// Shared constants and types for the memory arbiter slice.
//   ADDR_W  : requester/memory address width
//   DATA_W  : memory word width
//   DEPTH   : number of implemented words; higher addresses are out of range
//   owner_t : which requester owns the read currently in flight
package microcpu_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  // True when the address maps onto an implemented memory word.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return addr < DEPTH_A;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter.
//   clk, rst_n : clock and synchronous active-low reset
//   req[1:0]   : requests, bit 0 = instruction fetch, bit 1 = load/store
//   gnt[1:0]   : one-hot grant (combinational), all zero when no request
// last_grant remembers the previous winner (0 = fetch, 1 = load/store); on a
// conflict the other requester wins. It resets to "fetch" so the load/store
// port wins the first conflict after reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b0;
    end else if (gnt[1]) begin
      last_grant <= 1'b1;
    end else if (gnt[0]) begin
      last_grant <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port instruction/data memory between the
// instruction-fetch port (read-only) and the load/store port.
//   clk, rst_n              : clock, synchronous active-low reset
//   if_req/if_addr          : fetch request; if_gnt accepts it
//   if_rvalid/if_rdata/if_err : fetch response, one cycle after the grant
//   d_req/d_we/d_addr/d_wdata : load/store request; d_gnt accepts it
//   d_rvalid/d_rdata/d_err  : load response (d_err also flags a dropped store)
//   mem_*                   : memory command outputs and registered read data
//
// Handshake: a requester raises req with stable fields and holds them until
// the cycle in which its gnt is high; that cycle is the transfer. At most one
// gnt is high per cycle. Read responses arrive as a one-cycle rvalid pulse
// exactly one cycle after the grant, with no back-pressure.
module mem_arbiter
  import microcpu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_data_out
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       if_ok;
  logic       d_ok;
  logic       d_load;
  logic       d_store;
  owner_t     pend_owner;
  logic       pend_err;
  logic       st_err_q;

  // Requests are masked while in reset so no grant (and no memory access)
  // can be issued.
  assign req = {d_req & rst_n, if_req & rst_n};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign if_gnt  = gnt[0];
  assign d_gnt   = gnt[1];
  assign if_ok   = in_range(if_addr);
  assign d_ok    = in_range(d_addr);
  assign d_load  = d_gnt & ~d_we;
  assign d_store = d_gnt & d_we;

  // Out-of-range accesses are granted but never reach the memory.
  always_comb begin
    mem_address      = '0;
    mem_data_in      = '0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    if (if_gnt) begin
      mem_address     = if_addr;
      mem_read_enable = if_ok;
    end else if (d_gnt) begin
      mem_address      = d_addr;
      mem_read_enable  = d_load & d_ok;
      mem_write_enable = d_store & d_ok;
      if (d_we) begin
        mem_data_in = d_wdata;
      end
    end
  end

  // Track who owns the read returning next cycle, and whether it faulted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_owner <= OWN_NONE;
      pend_err   <= 1'b0;
      st_err_q   <= 1'b0;
    end else begin
      if (if_gnt) begin
        pend_owner <= OWN_IF;
      end else if (d_load) begin
        pend_owner <= OWN_D;
      end else begin
        pend_owner <= OWN_NONE;
      end
      pend_err <= (if_gnt & ~if_ok) | (d_load & ~d_ok);
      st_err_q <= d_store & ~d_ok;
    end
  end

  // Responses are additionally gated by rst_n so a read granted just before
  // reset never surfaces while reset is asserted.
  always_comb begin
    if_rvalid = rst_n && (pend_owner == OWN_IF);
    d_rvalid  = rst_n && (pend_owner == OWN_D);
    if_err    = if_rvalid & pend_err;
    d_err     = (d_rvalid & pend_err) | (rst_n & st_err_q);
    if_rdata  = (if_rvalid && !pend_err) ? mem_data_out : '0;
    d_rdata   = (d_rvalid && !pend_err) ? mem_data_out : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import microcpu_mem_pkg::*;

  localparam int W = 20;  // {if_v, d_v, if_err, d_err, data[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_rvalid, if_err;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_gnt, d_rvalid, d_err;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_write_enable, mem_read_enable;
  logic [DATA_W-1:0] mem_data_out = '0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_data_out(mem_data_out)
  );

  // ---------------- memory model (registered read) ----------------
  logic [DATA_W-1:0] tb_mem  [256];
  logic [DATA_W-1:0] ref_mem [256];

  always @(posedge clk) begin
    if (mem_write_enable) tb_mem[mem_address[7:0]] <= mem_data_in;
    if (mem_read_enable)  mem_data_out <= tb_mem[mem_address[7:0]];
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              exp_if_gnt;
    logic              exp_d_gnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ir, input logic [ADDR_W-1:0] ia,
                              input logic dr, input logic dw,
                              input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd,
                              input logic eig, input logic edg);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw;
    v.d_addr = da; v.d_wdata = dd; v.exp_if_gnt = eig; v.exp_d_gnt = edg;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; drives one cycle, checks it, and returns
  // just after the next rising edge.
  task automatic step(input vec_t v);
    logic [W-1:0]      e;
    logic [W-1:0]      nx;
    logic              oor;
    logic              exp_re, exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_din;
    if_req = v.if_req; if_addr = v.if_addr;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    @(negedge clk);
    e = '0;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
    end
    chk("if_rvalid", 32'(if_rvalid), 32'(e[19]));
    chk("d_rvalid",  32'(d_rvalid),  32'(e[18]));
    chk("if_err",    32'(if_err),    32'(e[17]));
    chk("d_err",     32'(d_err),     32'(e[16]));
    chk("if_rdata",  32'(if_rdata),  e[19] ? 32'(e[15:0]) : 32'd0);
    chk("d_rdata",   32'(d_rdata),   e[18] ? 32'(e[15:0]) : 32'd0);
    chk("if_gnt",    32'(if_gnt),    32'(v.exp_if_gnt));
    chk("d_gnt",     32'(d_gnt),     32'(v.exp_d_gnt));

    nx = '0; exp_re = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_din = '0;
    if (v.exp_if_gnt) begin
      oor = (v.if_addr >= 12'd256);
      exp_re = !oor; exp_addr = v.if_addr;
      nx = {1'b1, 1'b0, oor, 1'b0, oor ? 16'h0000 : ref_mem[v.if_addr[7:0]]};
    end else if (v.exp_d_gnt) begin
      oor = (v.d_addr >= 12'd256);
      exp_addr = v.d_addr;
      if (v.d_we) begin
        exp_we = !oor; exp_din = v.d_wdata;
        nx = {1'b0, 1'b0, 1'b0, oor, 16'h0000};
        if (!oor) ref_mem[v.d_addr[7:0]] = v.d_wdata;
      end else begin
        exp_re = !oor;
        nx = {1'b0, 1'b1, 1'b0, oor, oor ? 16'h0000 : ref_mem[v.d_addr[7:0]]};
      end
    end
    chk("mem_read_enable",  32'(mem_read_enable),  32'(exp_re));
    chk("mem_write_enable", 32'(mem_write_enable), 32'(exp_we));
    if (exp_re || exp_we) chk("mem_address", 32'(mem_address), 32'(exp_addr));
    if (exp_we) chk("mem_data_in", 32'(mem_data_in), 32'(exp_din));
    exp_q.push_back(nx);
    @(posedge clk); #1;
  endtask

  // Holds reset for one cycle with the given requests pending; nothing may be
  // granted or returned meanwhile, and any read in flight is discarded.
  task automatic do_reset(input logic ir, input logic dr);
    if_req = ir; if_addr = 12'h006;
    d_req = dr; d_we = 1'b0; d_addr = 12'h003;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_if_gnt",    32'(if_gnt),           32'd0);
    chk("rst_d_gnt",     32'(d_gnt),            32'd0);
    chk("rst_mem_re",    32'(mem_read_enable),  32'd0);
    chk("rst_mem_we",    32'(mem_write_enable), 32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid),        32'd0);
    chk("rst_d_rvalid",  32'(d_rvalid),         32'd0);
    chk("rst_if_err",    32'(if_err),           32'd0);
    chk("rst_d_err",     32'(d_err),            32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back('0);
  endtask

  // ---------------- test ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
    end
    ref_mem[5] = 16'h1234;
    for (int i = 0; i < 256; i++) tb_mem[i] = ref_mem[i];

    // Vector table: expected grants derived by hand from round-robin rules.
    vecs.push_back(mk(1, 12'h005, 0, 0, 12'h000, 16'h0000, 1, 0)); // single fetch
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h000, 16'h0000, 0, 0)); // idle
    vecs.push_back(mk(1, 12'h011, 1, 0, 12'h010, 16'h0000, 0, 1)); // conflict: D first
    vecs.push_back(mk(1, 12'h011, 1, 0, 12'h010, 16'h0000, 1, 0)); // then IF
    vecs.push_back(mk(1, 12'h011, 1, 0, 12'h010, 16'h0000, 0, 1));
    vecs.push_back(mk(1, 12'h011, 1, 0, 12'h010, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 12'h000, 1, 1, 12'h020, 16'hBEEF, 0, 1)); // store
    vecs.push_back(mk(0, 12'h000, 1, 0, 12'h020, 16'h0000, 0, 1)); // load same addr
    vecs.push_back(mk(0, 12'h000, 1, 0, 12'h100, 16'h0000, 0, 1)); // OOR load
    vecs.push_back(mk(0, 12'h000, 1, 1, 12'h3FF, 16'hCAFE, 0, 1)); // OOR store
    vecs.push_back(mk(1, 12'h030, 1, 0, 12'h031, 16'h0000, 1, 0)); // last=D: IF wins
    vecs.push_back(mk(0, 12'h000, 1, 0, 12'h031, 16'h0000, 0, 1)); // held D
    for (int a = 0; a < 8; a++) begin
      vecs.push_back(mk(1, 12'(a), 0, 0, 12'h000, 16'h0000, 1, 0)); // back-to-back fetch
    end
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h000, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 12'h200, 0, 0, 12'h000, 16'h0000, 1, 0)); // OOR fetch
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h000, 16'h0000, 0, 0));
    for (int k = 0; k < 6; k++) begin
      logic [ADDR_W-1:0] ra;
      ra = 12'($urandom_range(0, 255));
      vecs.push_back(mk(1, ra, 0, 0, 12'h000, 16'h0000, 1, 0));
    end
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h000, 16'h0000, 0, 0));

    do_reset(1'b0, 1'b0);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Fetch granted, reset next cycle: the in-flight read is dropped.
    step(mk(1, 12'h006, 0, 0, 12'h000, 16'h0000, 1, 0));
    do_reset(1'b1, 1'b1);
    step(mk(1, 12'h001, 1, 0, 12'h002, 16'h0000, 0, 1)); // first conflict: D
    step(mk(0, 12'h000, 1, 0, 12'h003, 16'h0000, 0, 1)); // leaves last=D
    do_reset(1'b0, 1'b0);
    step(mk(1, 12'h004, 1, 0, 12'h005, 16'h0000, 0, 1)); // reset restored last=IF
    step(mk(0, 12'h000, 0, 0, 12'h000, 16'h0000, 0, 0));
    step(mk(0, 12'h000, 0, 0, 12'h000, 16'h0000, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
